// File: rtl/down_counter_jk_pkg.sv
// Shared constants for the JK-flop based counters.
package down_counter_jk_pkg;

  // JK select codes, indexed as {J,K}
  localparam logic [1:0] JK_HOLD = 2'b00;
  localparam logic [1:0] JK_CLR  = 2'b01;
  localparam logic [1:0] JK_SET  = 2'b10;
  localparam logic [1:0] JK_TGL  = 2'b11;

  // Default counter width, common to the up and down counters
  localparam int unsigned DEFAULT_WIDTH = 4;

endpackage

// File: rtl/down_counter_jk_jk_ff_mux.sv
// Single JK flip-flop whose next state is a 4:1 mux selected by {J,K}.
module jk_ff_mux
  import down_counter_jk_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic j,
  input  logic k,
  output logic q
);

  logic d;

  // Next-state mux: hold / clear / set / toggle
  always_comb begin
    d = q;
    case ({j, k})
      JK_HOLD: d = q;
      JK_CLR:  d = 1'b0;
      JK_SET:  d = 1'b1;
      JK_TGL:  d = ~q;
      default: d = q;
    endcase
  end

  // State bit, asynchronously cleared
  always_ff @(posedge clk or posedge reset) begin
    if (reset) q <= 1'b0;
    else       q <= d;
  end

endmodule

// File: rtl/down_counter_jk.sv
// Synchronous down counter from JK flops with load, enable, zero flag and borrow pulse.
module down_counter_jk
  import down_counter_jk_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             zero,
  output logic             borrow
);

  logic [WIDTH-1:0] t;
  logic [WIDTH-1:0] j;
  logic [WIDTH-1:0] k;

  // Toggle chain: bit i flips when every lower bit is zero
  always_comb begin
    t    = '0;
    t[0] = 1'b1;
    for (int unsigned i = 1; i < WIDTH; i++) begin
      t[i] = t[i-1] & ~count[i-1];
    end
  end

  // J/K select: load forces set/clear per bit, enable toggles along the chain
  always_comb begin
    j = '0;
    k = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (load) begin
        {j[i], k[i]} = load_val[i] ? JK_SET : JK_CLR;
      end else if (en) begin
        {j[i], k[i]} = t[i] ? JK_TGL : JK_HOLD;
      end else begin
        {j[i], k[i]} = JK_HOLD;
      end
    end
  end

  // One JK flop per count bit
  for (genvar g = 0; g < int'(WIDTH); g++) begin : g_bit
    jk_ff_mux u_ff (
      .clk   (clk),
      .reset (reset),
      .j     (j[g]),
      .k     (k[g]),
      .q     (count[g])
    );
  end

  // Zero flag decoded straight from the registered count
  assign zero = (count == '0);

  // Borrow pulses only on a counting edge that leaves zero
  always_ff @(posedge clk or posedge reset) begin
    if (reset) borrow <= 1'b0;
    else       borrow <= ~load & en & (count == '0);
  end

endmodule

// File: tb/tb_down_counter_jk.sv
// Scoreboard bench for down_counter_jk with directed and random stimulus.
module tb_down_counter_jk;

  localparam int unsigned W = 4;

  logic         clk;
  logic         reset;
  logic         en;
  logic         load;
  logic [W-1:0] load_val;
  logic [W-1:0] count;
  logic         zero;
  logic         borrow;

  typedef struct {
    int    c;
    bit    z;
    bit    b;
    string tag;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;
  int   m     = 0;   // reference count value
  event async_chk;

  down_counter_jk #(.WIDTH(W)) dut (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .load     (load),
    .load_val (load_val),
    .count    (count),
    .zero     (zero),
    .borrow   (borrow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: one clock edge worth of behaviour, pushed to the scoreboard
  task automatic step(input bit r, input bit e, input bit ld, input int lv, input string tag);
    exp_t x;
    bit   b;
    @(negedge clk);
    reset    = r;
    en       = e;
    load     = ld;
    load_val = W'(lv);
    b = 1'b0;
    if (r)       m = 0;
    else if (ld) m = lv % (1 << W);
    else if (e) begin
      b = (m == 0);
      m = (m + (1 << W) - 1) % (1 << W);
    end
    x.c = m; x.z = (m == 0); x.b = b; x.tag = tag;
    q.push_back(x);
  endtask

  // Assert reset between edges and expect the outputs to clear without a clock
  task automatic async_reset(input string tag);
    exp_t x;
    @(negedge clk);
    #1;
    reset = 1'b1;
    m = 0;
    x.c = 0; x.z = 1'b1; x.b = 1'b0; x.tag = tag;
    q.push_back(x);
    -> async_chk;
    #2;
  endtask

  task automatic cmp(input string tag, input string what, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s %s got=%0d exp=%0d t=%0t", tag, what, got, exp, $time);
    end
  endtask

  // Monitor: compares DUT outputs whenever an expectation is pending
  initial begin
    exp_t x;
    forever begin
      @(posedge clk or async_chk);
      #1;
      if (q.size() > 0) begin
        x = q.pop_front();
        if ($isunknown({count, zero, borrow})) begin
          total++; bad++;
          $display("FAIL %s unknown outputs count=%b zero=%b borrow=%b", x.tag, count, zero, borrow);
        end else begin
          cmp(x.tag, "count",  int'(count),  x.c);
          cmp(x.tag, "zero",   int'(zero),   int'(x.z));
          cmp(x.tag, "borrow", int'(borrow), int'(x.b));
        end
      end
    end
  end

  initial begin
    exp_t x;
    reset = 1'b0; en = 1'b0; load = 1'b0; load_val = '0;
    // Reset applied with no clock edge
    #2;
    reset = 1'b1;
    m = 0;
    x.c = 0; x.z = 1'b1; x.b = 1'b0; x.tag = "por";
    q.push_back(x);
    -> async_chk;

    step(1, 1, 1, 7, "in_reset");
    step(1, 1, 0, 0, "in_reset");

    // Two full count cycles, wrapping twice
    for (int i = 0; i < 32; i++) step(0, 1, 0, 0, "full_cycle");

    // Load priority over enable
    step(0, 0, 1, 3, "load3");
    step(0, 1, 1, 9, "load_prio");
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0, "after_load");

    // Hold at 6, then resume
    step(0, 0, 1, 6, "load6");
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0, "hold");
    step(0, 1, 0, 0, "resume");

    // Reset mid-count, then wrap on release
    step(0, 0, 1, 11, "load11");
    step(0, 1, 0, 0, "count10");
    async_reset("mid_reset");
    step(0, 1, 0, 0, "release_wrap");
    step(0, 1, 0, 0, "release_next");

    // Load zero then wrap
    step(0, 0, 1, 0, "load0");
    step(0, 1, 0, 0, "load0_wrap");

    // Randomized traffic
    for (int i = 0; i < 300; i++) begin
      step(($urandom_range(0, 39) == 0), ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 4) == 0), int'($urandom_range(0, (1 << W) - 1)), "random");
    end

    repeat (2) @(posedge clk);
    #3;
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain pending=%0d exp=0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/down_counter_jk.md
# down_counter_jk

Synchronous down counter built from MUX-based JK flip-flops. It is the counting-down counterpart of the team's up counter and shares the same clock, reset and count-bus conventions. It adds parallel load, count enable, a zero flag and a one-cycle borrow pulse on wrap-around. Downstream logic can use it as a reload/timeout counter or to check a sequence against the up counter.

## Interface
Parameters:
- WIDTH, 4, counter width in bits; legal range 2..16.

Ports:
- clk  input  1  rising-edge clock; the only clock.
- reset  input  1  asynchronous, active-high reset.
- en  input  1  count enable; decrement by one per enabled edge.
- load  input  1  parallel load strobe; overrides en.
- load_val  input  WIDTH  value loaded when load=1.
- count  output  WIDTH  current counter value (registered).
- zero  output  1  high while count == 0 (decoded from registered count).
- borrow  output  1  one-cycle pulse (registered) marking a wrap from 0 to all-ones.

## Operation
- Each bit i is one JK flop. Its next state comes from a 4:1 MUX indexed by {J,K}:
  - 00 hold
  - 01 clear
  - 10 set
  - 11 toggle
- Priority at each rising clk edge: reset > load > en > hold.
- Load: for every bit, J = load_val[i] and K = ~load_val[i]. count becomes load_val. borrow = 0.
- Count (en=1, load=0): J = K = T[i].
  - T[0] = 1.
  - T[i] = 1 when all bits below i are 0.
  - This gives a synchronous decrement with no ripple.
- Wrap: when count == 0 and a count edge occurs, count becomes 2^WIDTH-1 and borrow = 1 for that cycle only.
- Hold (en=0, load=0): J = K = 0 on all bits. count is unchanged. borrow = 0.
- borrow is 0 on every edge that is not a wrap, so it never stretches beyond one cycle.
- Asynchronous reset: count = 0, borrow = 0, and therefore zero = 1. These take effect immediately, without a clock edge.
- Arithmetic is modulo 2^WIDTH. There is no saturation.

## Timing
- Latency: count, borrow and zero reflect load/en sampled at edge N in the cycle after edge N. zero is combinational from count, so it has no extra cycle.
- load and en are sampled only at rising clk. Glitches between edges have no effect.
- load=1 with en=1: the load wins. No decrement and no borrow.
- load with load_val == 0: count = 0, zero = 1, borrow = 0. The next enabled edge wraps and asserts borrow.
- Reset asserted mid-count: outputs go to their reset values within the same cycle, asynchronously. All inputs are ignored while reset = 1.
- Reset deasserted: the first edge with reset = 0 applies normal priority. With en = 1 at that edge, count becomes 2^WIDTH-1 and borrow = 1.
- No combinational path exists from any input to any output.

## Structure
- The shared package holds:
  - JK select constants: JK_HOLD = 2'b00, JK_CLR = 2'b01, JK_SET = 2'b10, JK_TGL = 2'b11.
  - The default counter width constant, shared with the up counter.
- Sub-module jk_ff_mux: one JK flop whose next state is a 4:1 MUX on {J,K}, with clk and asynchronous active-high reset to 0. It is instantiated WIDTH times with a generate loop.
- The top level contains:
  - the toggle-chain logic T[i];
  - the load/en MUX that drives J/K;
  - the zero decode;
  - the borrow register.

## Test plan
- Reset: assert reset with no clock edge. count = 0, zero = 1 and borrow = 0 immediately.
- First wrap: release reset with en = 1 and load = 0.
  - Next edge: count = 15 (WIDTH = 4), borrow = 1 for one cycle, zero = 0.
  - Following edges: count 14, 13, and so on, with borrow = 0.
- Full cycle: with en held at 1 for 32 edges after reset, count follows 15..0 twice and borrow pulses exactly twice, each time on the 0→15 transition.
- Load priority: from count = 3, drive load = 1, en = 1, load_val = 9. Next edge: count = 9, borrow = 0. Then en-only edges give 8, 7, ...
- Hold: set en = 0 at count = 6 for 5 edges. count stays 6 and borrow stays 0. Re-enable: count = 5.
- Reset mid-operation: at count = 11 with en = 1, assert reset between edges. count = 0 asynchronously. After release with en = 1, the next edge gives 15 with borrow = 1.
